// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep/capture block.
package tt_pkg;

  localparam int unsigned N_INPUTS = 7;
  localparam int unsigned TT_W     = 2 ** N_INPUTS;

  typedef logic [TT_W-1:0]     tt_t;
  typedef logic [N_INPUTS-1:0] tt_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StSample,
    StCmp
  } tt_state_e;

  // Reference signature of the classified 7-input majority network.
  localparam tt_t TT_MAJ_NET = 128'hfee8eaa8eaa8eaa8eaa8eaa8eaa8e880;

endpackage

// File: rtl/tt_first_diff.sv
// Lowest-set-bit encoder; idx_o is all-ones and none_o is high when vec_i is zero.
module tt_first_diff
  import tt_pkg::*;
(
  input  logic [TT_W-1:0]     vec_i,
  output logic [N_INPUTS-1:0] idx_o,
  output logic                none_o
);

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    idx_o  = '1;
    none_o = 1'b1;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o  = N_INPUTS'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps every input vector into a combinational function, captures its truth table and
// compares it with a latched reference signature.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [TT_W-1:0]     expected,
  output logic [N_INPUTS-1:0] x,
  input  logic                f_in,
  output logic                busy,
  output logic                done,
  output logic [TT_W-1:0]     truth_table,
  output logic                match,
  output logic [N_INPUTS-1:0] mismatch_idx
);

  localparam logic [N_INPUTS:0] LastIdx = (N_INPUTS + 1)'(TT_W - 1);
  localparam logic [N_INPUTS:0] IdxOne  = (N_INPUTS + 1)'(1);
  localparam logic [3:0]        Settle  = 4'(SETTLE_CYCLES);

  tt_state_e         state_q, state_d;
  logic [N_INPUTS:0] idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  tt_idx_t           x_q, x_d;
  tt_t               tt_q, tt_d;
  tt_t               exp_q, exp_d;
  logic              match_q, match_d;
  tt_idx_t           mis_q, mis_d;

  tt_t               tt_sampled;
  tt_idx_t           diff_idx;
  logic              diff_none;
  logic              busy_w;

  // f_in only reaches state through this path, and only in StSample.
  always_comb begin
    tt_sampled = tt_q;
    tt_sampled[idx_q[N_INPUTS-1:0]] = f_in;
  end

  tt_first_diff u_first_diff (
    .vec_i  (tt_sampled ^ exp_q),
    .idx_o  (diff_idx),
    .none_o (diff_none)
  );

  assign busy_w = (state_q == StDrive) || (state_q == StWait) || (state_q == StSample);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    tt_d    = tt_q;
    exp_d   = exp_q;
    match_d = match_q;
    mis_d   = mis_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StDrive;
          idx_d   = '0;
          exp_d   = expected;
          tt_d    = '0;
          match_d = 1'b0;
          mis_d   = '1;
        end
      end
      StDrive: begin
        x_d     = idx_q[N_INPUTS-1:0];
        cnt_d   = Settle;
        state_d = (Settle == 4'd0) ? StSample : StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StSample;
      end
      StSample: begin
        tt_d = tt_sampled;
        if (idx_q == LastIdx) begin
          state_d = StCmp;
          match_d = diff_none;
          mis_d   = diff_idx;
        end else begin
          idx_d   = idx_q + IdxOne;
          state_d = StDrive;
        end
      end
      StCmp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort keeps the partial capture; the in-flight sample is dropped.
    if (busy_w && abort) begin
      state_d = StIdle;
      x_d     = '0;
      tt_d    = tt_q;
      match_d = 1'b0;
      mis_d   = mis_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
      mis_q   <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      tt_q    <= tt_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      mis_q   <= mis_d;
    end
  end

  assign x            = x_q;
  assign busy         = busy_w;
  assign done         = (state_q == StCmp);
  assign truth_table  = tt_q;
  assign match        = match_q;
  assign mismatch_idx = mis_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture at settle lengths 1 (main), 0 and 3.
module tb_tt_sweep_capture;
  import tt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  tt_t  expected = '0;
  int   mode = 0;

  tt_idx_t x1, x0, x3, mis1, mis0, mis3;
  logic    f1, f0, f3, busy1, busy0, busy3, done1, done0, done3, match1, match0, match3;
  tt_t     tt1, tt0, tt3;

  int n_checks = 0;
  int n_errors = 0;

  // 0: tied low, 1: tied high, 2: network signature ROM, 3: 7-input majority.
  function automatic logic fut(input int m, input tt_idx_t xv);
    tt_t net;
    net = TT_MAJ_NET;
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return net[xv];
      default: return ($countones(xv) >= 4);
    endcase
  endfunction

  assign f1 = fut(mode, x1);
  assign f0 = fut(mode, x0);
  assign f3 = fut(mode, x3);

  always #5 clk = ~clk;

  tt_sweep_capture #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .x(x1), .f_in(f1), .busy(busy1), .done(done1), .truth_table(tt1), .match(match1),
    .mismatch_idx(mis1)
  );

  tt_sweep_capture #(.SETTLE_CYCLES(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .x(x0), .f_in(f0), .busy(busy0), .done(done0), .truth_table(tt0), .match(match0),
    .mismatch_idx(mis0)
  );

  tt_sweep_capture #(.SETTLE_CYCLES(3)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .x(x3), .f_in(f3), .busy(busy3), .done(done3), .truth_table(tt3), .match(match3),
    .mismatch_idx(mis3)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Start pulse in window 0; window k follows the k-th rising edge after it.
  task automatic run_sweep(input int abort_at, input int s2a, input int s2b, input int flip_at,
                           output int k1, output int k0, output int k3,
                           output int c1, output int c0, output int c3,
                           output logic busy_ab);
    k1 = -1; k0 = -1; k3 = -1;
    c1 = 0;  c0 = 0;  c3 = 0;
    busy_ab = 1'b1;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    for (int k = 1; k <= 650; k++) begin
      @(posedge clk);
      #1;
      start = (k == s2a) || (k == s2b);
      abort = (k == abort_at);
      if (k == flip_at) expected = ~expected;
      @(negedge clk);
      if (done1) begin c1++; if (k1 < 0) k1 = k; end
      if (done0) begin c0++; if (k0 < 0) k0 = k; end
      if (done3) begin c3++; if (k3 < 0) k3 = k; end
      if (k == abort_at + 1) busy_ab = busy1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   k1, k0, k3, c1, c0, c3;
    logic bab;
    tt_t  maj_tt;

    repeat (3) @(negedge clk);
    check_eq("rst_x", x1, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_done", done1, 0);
    check_eq("rst_tt", tt1, 0);
    check_eq("rst_match", match1, 0);
    check_eq("rst_mis", mis1, 7'h7f);
    rst_n = 1'b1;

    // Majority network against its own signature.
    mode = 2;
    expected = TT_MAJ_NET;
    run_sweep(-1, -1, -1, -1, k1, k0, k3, c1, c0, c3, bab);
    check_eq("net_lat_s1", k1, 385);
    check_eq("net_lat_s0", k0, 257);
    check_eq("net_lat_s3", k3, 641);
    check_eq("net_done_cnt", c1, 1);
    check_eq("net_match", match1, 1);
    check_eq("net_mis", mis1, 7'h7f);
    check_eq("net_tt", tt1, 128'hfee8eaa8eaa8eaa8eaa8eaa8eaa8e880);
    check_eq("net_tt_s0", tt0, 128'hfee8eaa8eaa8eaa8eaa8eaa8eaa8e880);
    check_eq("net_match_s3", match3, 1);
    check_eq("net_busy_after", busy1, 0);

    expected = TT_MAJ_NET ^ (tt_t'(1) << 5);
    run_sweep(-1, -1, -1, -1, k1, k0, k3, c1, c0, c3, bab);
    check_eq("flip5_match", match1, 0);
    check_eq("flip5_mis", mis1, 5);
    check_eq("flip5_mis_s3", mis3, 5);

    expected = TT_MAJ_NET ^ (tt_t'(1) << 127);
    run_sweep(-1, -1, -1, -1, k1, k0, k3, c1, c0, c3, bab);
    check_eq("flip127_match", match1, 0);
    check_eq("flip127_mis", mis1, 127);

    mode = 0;
    expected = '0;
    run_sweep(-1, -1, -1, -1, k1, k0, k3, c1, c0, c3, bab);
    check_eq("zero_match", match1, 1);
    check_eq("zero_tt", tt1, 0);

    mode = 1;
    run_sweep(-1, -1, -1, -1, k1, k0, k3, c1, c0, c3, bab);
    check_eq("one_tt", tt1, {128{1'b1}});
    check_eq("one_mis", mis1, 0);
    check_eq("one_match", match1, 0);

    // True majority; expected is inverted mid-sweep and must be ignored.
    mode = 3;
    for (int i = 0; i < 128; i++) maj_tt[i] = ($countones(i[6:0]) >= 4);
    expected = maj_tt;
    run_sweep(-1, -1, -1, 50, k1, k0, k3, c1, c0, c3, bab);
    check_eq("maj_match", match1, 1);
    check_eq("maj_tt", tt1, maj_tt);
    check_eq("maj_mis", mis1, 7'h7f);

    mode = 2;
    expected = TT_MAJ_NET;
    run_sweep(100, -1, -1, -1, k1, k0, k3, c1, c0, c3, bab);
    check_eq("abort_busy", bab, 0);
    check_eq("abort_no_done", c1, 0);
    check_eq("abort_no_done_s3", c3, 0);
    check_eq("abort_tt_hi", tt1[127:33], 0);
    check_eq("abort_tt_lo", tt1[32:0], 33'h0eaa8e880);
    check_eq("abort_match", match1, 0);
    check_eq("abort_x", x1, 0);

    run_sweep(-1, -1, -1, -1, k1, k0, k3, c1, c0, c3, bab);
    check_eq("post_abort_match", match1, 1);
    check_eq("post_abort_done", c1, 1);

    run_sweep(-1, 10, 200, -1, k1, k0, k3, c1, c0, c3, bab);
    check_eq("restart_lat", k1, 385);
    check_eq("restart_done_cnt", c1, 1);
    check_eq("restart_match", match1, 1);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_eq("start_abort_idle", busy1, 0);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy1, 0);
    check_eq("midrst_done", done1, 0);
    check_eq("midrst_x", x1, 0);
    check_eq("midrst_tt", tt1, 0);
    check_eq("midrst_match", match1, 0);
    check_eq("midrst_mis", mis1, 7'h7f);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(-1, -1, -1, -1, k1, k0, k3, c1, c0, c3, bab);
    check_eq("midrst_fresh_lat", k1, 385);
    check_eq("midrst_fresh_match", match1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
